// File: rtl/regfile_hilo_pkg.sv
// -----------------------------------------------------------------------------
// regfile_hilo_pkg
// Shared widths and constants for the MIPS-style register file and the HI/LO
// pair. Imported by regfile_hilo and hilo_reg.
// -----------------------------------------------------------------------------
package regfile_hilo_pkg;

  localparam int RegBus     = 32;   // data word width
  localparam int RegAddrBus = 5;    // GPR address width
  localparam int RegNum     = 32;   // number of GPRs, r0 included

  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;
  localparam logic                  ReadEnable   = 1'b1;
  localparam logic                  ReadDisable  = 1'b0;
  localparam logic                  RstEnable    = 1'b1;

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// -----------------------------------------------------------------------------
// hilo_reg
// HI/LO multiply/divide result registers with optional write-through bypass.
// Optional feature macro: REGFILE_BYPASS_EN (hilo_we forwards hi_i/lo_i to the
// outputs in the same cycle).
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, clears HI and LO
//   we      HI/LO write enable from write-back
//   hi_i    HI write data
//   lo_i    LO write data
//   hi_o    HI value to execute (0 while rst=1)
//   lo_o    LO value to execute (0 while rst=1)
// -----------------------------------------------------------------------------
module hilo_reg
  import regfile_hilo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RegBus-1:0] hi_i,
  input  logic [RegBus-1:0] lo_i,
  output logic [RegBus-1:0] hi_o,
  output logic [RegBus-1:0] lo_o
);

  logic [RegBus-1:0] hi_q;
  logic [RegBus-1:0] lo_q;

  // Storage: reset wins over a write presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q <= ZeroWord;
      lo_q <= ZeroWord;
    end else if (we == WriteEnable) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  // Outputs: forced to zero during reset so execute never sees stale values.
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst == RstEnable) begin
      hi_o = ZeroWord;
      lo_o = ZeroWord;
    end
`ifdef REGFILE_BYPASS_EN
    else if (we == WriteEnable) begin
      hi_o = hi_i;
      lo_o = lo_i;
    end
`endif
  end

endmodule

// File: rtl/regfile_hilo.sv
// -----------------------------------------------------------------------------
// regfile_hilo
// 32 x 32-bit general purpose register file (r0 hardwired to zero) with two
// combinational read ports, one write port, plus the HI/LO register pair.
// Optional feature macro: REGFILE_BYPASS_EN (a read of the address being
// written this cycle returns wdata; HI/LO writes forward likewise).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   we, waddr, wdata    GPR write port (write-back stage)
//   re1, raddr1, rdata1 read port 1 (rdata1 = 0 when re1=0)
//   re2, raddr2, rdata2 read port 2 (rdata2 = 0 when re2=0)
//   hilo_we, hi_i, lo_i HI/LO write port
//   hi_o, lo_o          HI/LO values to execute
// -----------------------------------------------------------------------------
module regfile_hilo
  import regfile_hilo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic [RegBus-1:0]     wdata,
  input  logic                  re1,
  input  logic [RegAddrBus-1:0] raddr1,
  output logic [RegBus-1:0]     rdata1,
  input  logic                  re2,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic [RegBus-1:0]     rdata2,
  input  logic                  hilo_we,
  input  logic [RegBus-1:0]     hi_i,
  input  logic [RegBus-1:0]     lo_i,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o
);

  logic [RegBus-1:0] gpr [RegNum];

  // Write port: r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < RegNum; i++) begin
        gpr[i] <= ZeroWord;
      end
    end else if ((we == WriteEnable) && (waddr != NOPRegAddr)) begin
      gpr[waddr] <= wdata;
    end
  end

  // Read port 1
  always_comb begin
    rdata1 = ZeroWord;
    if ((rst != RstEnable) && (re1 == ReadEnable) && (raddr1 != NOPRegAddr)) begin
`ifdef REGFILE_BYPASS_EN
      if ((we == WriteEnable) && (raddr1 == waddr)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = gpr[raddr1];
      end
`else
      rdata1 = gpr[raddr1];
`endif
    end
  end

  // Read port 2
  always_comb begin
    rdata2 = ZeroWord;
    if ((rst != RstEnable) && (re2 == ReadEnable) && (raddr2 != NOPRegAddr)) begin
`ifdef REGFILE_BYPASS_EN
      if ((we == WriteEnable) && (raddr2 == waddr)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = gpr[raddr2];
      end
`else
      rdata2 = gpr[raddr2];
`endif
    end
  end

  hilo_reg u_hilo_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (hilo_we),
    .hi_i (hi_i),
    .lo_i (lo_i),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

endmodule
